// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO bank: register offsets, CFG version, IRQ grouping.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wb_gpio_pkg;

   // Byte offsets of the registers inside the 256-byte window
   localparam logic [7:0] OFS_OUT  = 8'h00;
   localparam logic [7:0] OFS_OEB  = 8'h04;
   localparam logic [7:0] OFS_IN   = 8'h08;
   localparam logic [7:0] OFS_IEN  = 8'h0C;
   localparam logic [7:0] OFS_RISE = 8'h10;
   localparam logic [7:0] OFS_PEND = 8'h14;
   localparam logic [7:0] OFS_CFG  = 8'h18;

   // Reported in the top byte of CFG so software can detect the register layout
   localparam logic [7:0] CFG_VERSION = 8'h01;

   // Pins are dealt round-robin onto the interrupt lines
   function automatic int irq_group(input int i, input int irq_w);
      return i % irq_w;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Synchronises asynchronous pad inputs and flags the selected edge per pin.
// Latency: pin change reaches in_o after SYNC_STAGES cycles; edge_o is combinational from in_o and prev.
// Backpressure: none; samples every cycle.
module gpio_sync_edge #(
   parameter int N_IO        = 17,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N_IO-1:0] pin_i,
   input  logic [N_IO-1:0] rise_i,
   output logic [N_IO-1:0] in_o,
   output logic [N_IO-1:0] edge_o
);

   logic [N_IO-1:0] sync_q [SYNC_STAGES];
   logic [N_IO-1:0] prev_q;

   // Synchroniser chain plus one extra delayed copy for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= pin_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign in_o = sync_q[SYNC_STAGES-1];

   // rise_i picks rising (1) or falling (0) detection independently per pin
   assign edge_o = (rise_i & in_o & ~prev_q) | (~rise_i & ~in_o & prev_q);

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone-slave GPIO bank: pad output/direction registers, synchronised inputs, edge IRQs.
// Latency: ack one cycle after request; pin edge to PEND is SYNC_STAGES+1 cycles.
// Backpressure: at most one request in flight; next request is sampled only after ack drops.
module wb_gpio_bank
   import wb_gpio_pkg::*;
#(
   parameter int          N_IO        = 17,
   parameter int          IRQ_W       = 3,
   parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [N_IO-1:0]  io_in,
   output logic [N_IO-1:0]  io_out,
   output logic [N_IO-1:0]  io_oeb,
   output logic [IRQ_W-1:0] irq
);

   logic [N_IO-1:0] out_q,  out_d;
   logic [N_IO-1:0] oeb_q,  oeb_d;
   logic [N_IO-1:0] ien_q,  ien_d;
   logic [N_IO-1:0] rise_q, rise_d;
   logic [N_IO-1:0] pend_q, pend_d;
   logic            ack_q,  ack_d;
   logic [31:0]     dat_q,  dat_d;

   logic [N_IO-1:0] in_sync;
   logic [N_IO-1:0] edge_hit;
   logic [N_IO-1:0] wmask;
   logic [N_IO-1:0] wdata;
   logic [31:0]     rdata;
   logic [7:0]      ofs;
   logic            req;
   logic            wr_en;
   logic            unused_bits;

   gpio_sync_edge #(
      .N_IO        (N_IO),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk_i  (wb_clk_i),
      .rst_ni (wb_rst_ni),
      .pin_i  (io_in),
      .rise_i (rise_q),
      .in_o   (in_sync),
      .edge_o (edge_hit)
   );

   // Upper data/select bits are ignored when N_IO < 32
   assign unused_bits = ^{wbs_dat_i, wbs_sel_i};

   assign ofs   = wbs_adr_i[7:0];
   // Holding off while ack is high gives the one-cycle gap between back-to-back accesses
   assign req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
   assign wr_en = req & wbs_we_i;
   assign wdata = wbs_dat_i[N_IO-1:0];

   // Expand byte-lane selects to a per-pin write mask
   always_comb begin
      wmask = '0;
      for (int i = 0; i < N_IO; i++) begin
         wmask[i] = wbs_sel_i[i/8];
      end
   end

   // Read mux on the request address; unmapped offsets return 0
   always_comb begin
      rdata = '0;
      case (ofs)
         OFS_OUT:  rdata[N_IO-1:0] = out_q;
         OFS_OEB:  rdata[N_IO-1:0] = oeb_q;
         OFS_IN:   rdata[N_IO-1:0] = in_sync;
         OFS_IEN:  rdata[N_IO-1:0] = ien_q;
         OFS_RISE: rdata[N_IO-1:0] = rise_q;
         OFS_PEND: rdata[N_IO-1:0] = pend_q;
         OFS_CFG:  rdata = {CFG_VERSION, 8'd0, 8'(IRQ_W), 8'(N_IO)};
         default:  rdata = '0;
      endcase
   end

   // Next-state for the register file, handshake and pending flags
   always_comb begin
      out_d  = out_q;
      oeb_d  = oeb_q;
      ien_d  = ien_q;
      rise_d = rise_q;
      pend_d = pend_q;
      ack_d  = req;
      dat_d  = (req && !wbs_we_i) ? rdata : 32'd0;
      if (wr_en) begin
         case (ofs)
            OFS_OUT:  out_d  = (out_q  & ~wmask) | (wdata & wmask);
            OFS_OEB:  oeb_d  = (oeb_q  & ~wmask) | (wdata & wmask);
            OFS_IEN:  ien_d  = (ien_q  & ~wmask) | (wdata & wmask);
            OFS_RISE: rise_d = (rise_q & ~wmask) | (wdata & wmask);
            OFS_PEND: pend_d = pend_q & ~(wdata & wmask);
            default:  ;
         endcase
      end
      // Applied after the W1C so a coincident edge keeps the flag set
      pend_d = pend_d | (edge_hit & ien_q);
   end

   // State registers; reset parks all pins as inputs
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         out_q  <= '0;
         oeb_q  <= '1;
         ien_q  <= '0;
         rise_q <= '0;
         pend_q <= '0;
         ack_q  <= 1'b0;
         dat_q  <= '0;
      end else begin
         out_q  <= out_d;
         oeb_q  <= oeb_d;
         ien_q  <= ien_d;
         rise_q <= rise_d;
         pend_q <= pend_d;
         ack_q  <= ack_d;
         dat_q  <= dat_d;
      end
   end

   // Level interrupts: enabled pending pins OR-ed onto their group line
   always_comb begin
      irq = '0;
      for (int k = 0; k < IRQ_W; k++) begin
         for (int i = 0; i < N_IO; i++) begin
            if (irq_group(i, IRQ_W) == k) begin
               irq[k] = irq[k] | (pend_q[i] & ien_q[i]);
            end
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign io_out    = out_q;
   assign io_oeb    = oeb_q;

endmodule
